// File: rtl/calc_operand_entry_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_operand_entry_if
// Purpose  : Keypad-to-operand bundle between the key front end and the builder.
// Revision : 1.0
// ============================================================================
interface calc_operand_entry_if #(
   parameter int DATA_W = 32
);
   logic [3:0]        digit;
   logic              key_enter;
   logic              key_commit;
   logic              key_clear;
   logic [DATA_W-1:0] operand;
   logic [3:0]        digit_count;
   logic              busy;
   logic              valid;
   logic              err;

   modport master (
      output digit, key_enter, key_commit, key_clear,
      input  operand, digit_count, busy, valid, err
   );

   modport slave (
      input  digit, key_enter, key_commit, key_clear,
      output operand, digit_count, busy, valid, err
   );
endinterface
`default_nettype wire

// File: rtl/calc_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : calc_operand_entry
// Purpose  : Synchronised, edge-detected multi-digit BCD operand builder.
// Revision : 1.0
// ============================================================================
module calc_operand_entry #(
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   calc_operand_entry_if.slave  bus
);

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam longint unsigned c_max_val = pow10(DIGITS) - 64'd1;
   localparam logic [3:0]      c_digits  = 4'(DIGITS);

   generate
      if (DIGITS < 1 || DIGITS > 9 || SYNC_STAGES < 2 ||
          (DATA_W < 64 && c_max_val >= (64'd1 << DATA_W))) begin : g_param_check
         $error("calc_operand_entry: illegal DIGITS/DATA_W/SYNC_STAGES combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Key bit order in the conditioning pipeline: {clear, commit, enter}
   logic [SYNC_STAGES-1:0][2:0] r_sync;
   logic [2:0]                  r_prev;
   logic [2:0]                  w_evt;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_operand, w_operand_nxt;
   logic [3:0]        r_count, w_count_nxt;
   logic              r_err, w_err_nxt;
   logic              r_valid, w_valid_nxt;

   logic [DATA_W-1:0] w_times10;
   logic [DATA_W-1:0] w_digit_ext;
   logic [3:0]        w_count_inc;
   logic              w_digit_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], {bus.key_clear, bus.key_commit, bus.key_enter}};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_evt       = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_times10   = (r_operand << 3) + (r_operand << 1);
   assign w_digit_ext = DATA_W'(bus.digit);
   assign w_count_inc = r_count + 4'd1;
   assign w_digit_ok  = (bus.digit <= 4'd9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_operand <= '0;
         r_count   <= '0;
         r_err     <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_operand <= w_operand_nxt;
         r_count   <= w_count_nxt;
         r_err     <= w_err_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   // Priority is clear > commit > enter; a commit event always consumes the cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_operand_nxt = r_operand;
      w_count_nxt   = r_count;
      w_err_nxt     = r_err;
      w_valid_nxt   = 1'b0;

      if (w_evt[2]) begin
         w_state_nxt   = S_IDLE;
         w_operand_nxt = '0;
         w_count_nxt   = '0;
         w_err_nxt     = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_evt[1] && w_evt[0]) begin
                  if (!w_digit_ok) begin
                     w_err_nxt = 1'b1;
                  end else begin
                     w_operand_nxt = w_digit_ext;
                     w_count_nxt   = 4'd1;
                     if (c_digits == 4'd1) begin
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b1;
                     end else begin
                        w_state_nxt = S_ENTRY;
                     end
                  end
               end
            end
            S_ENTRY: begin
               if (w_evt[1]) begin
                  w_state_nxt = S_DONE;
                  w_valid_nxt = 1'b1;
               end else if (w_evt[0]) begin
                  if (!w_digit_ok) begin
                     w_err_nxt = 1'b1;
                  end else begin
                     w_operand_nxt = w_times10 + w_digit_ext;
                     w_count_nxt   = w_count_inc;
                     if (w_count_inc == c_digits) begin
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign bus.operand     = r_operand;
   assign bus.digit_count = r_count;
   assign bus.busy        = (r_state == S_ENTRY);
   assign bus.valid       = r_valid;
   assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_operand_entry
// Purpose  : Scoreboard bench driving a 4-digit and a 9-digit builder in parallel.
// Revision : 1.0
// ============================================================================
module tb_calc_operand_entry;
   localparam int SS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] digit = 4'd0;
   logic       k_ent = 1'b0;
   logic       k_cmt = 1'b0;
   logic       k_clr = 1'b0;

   always #5 clk = ~clk;

   calc_operand_entry_if #(.DATA_W(32)) bus4 ();
   calc_operand_entry_if #(.DATA_W(30)) bus9 ();

   assign bus4.digit = digit;  assign bus9.digit = digit;
   assign bus4.key_enter = k_ent;  assign bus9.key_enter = k_ent;
   assign bus4.key_commit = k_cmt; assign bus9.key_commit = k_cmt;
   assign bus4.key_clear = k_clr;  assign bus9.key_clear = k_clr;

   calc_operand_entry #(.DIGITS(4), .DATA_W(32), .SYNC_STAGES(SS)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave));
   calc_operand_entry #(.DIGITS(9), .DATA_W(30), .SYNC_STAGES(SS)) dut9 (
      .clk(clk), .rst(rst), .bus(bus9.slave));

   typedef struct {
      longint op;
      int     cnt;
   } exp_t;

   exp_t q4[$];
   exp_t q9[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per instance, the digits entered so far as a number.
   longint m_val  [2];
   int     m_cnt  [2];
   bit     m_done [2];
   bit     m_err  [2];
   int     m_max  [2] = '{4, 9};

   task automatic check(input string name, input logic [63:0] act, input longint exp);
      n_checks++;
      if (act !== 64'(exp)) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end
   endfunction

   task automatic model_event(input bit clr, input bit cmt, input bit ent, input logic [3:0] d);
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         bit fin;
         fin = 1'b0;
         if (clr) begin
            m_val[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0; m_err[i] = 1'b0;
         end else if (m_done[i]) begin
            fin = 1'b0;
         end else if (cmt) begin
            if (m_cnt[i] > 0) fin = 1'b1;
         end else if (ent) begin
            if (d > 9) m_err[i] = 1'b1;
            else begin
               m_val[i] = m_val[i] * 10 + longint'(d);
               m_cnt[i] = m_cnt[i] + 1;
               if (m_cnt[i] == m_max[i]) fin = 1'b1;
            end
         end
         if (fin) begin
            m_done[i] = 1'b1;
            e.op = m_val[i];
            e.cnt = m_cnt[i];
            if (i == 0) q4.push_back(e); else q9.push_back(e);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "/op4"},   bus4.operand,     m_val[0]);
      check({tag, "/cnt4"},  bus4.digit_count, m_cnt[0]);
      check({tag, "/err4"},  bus4.err,         m_err[0]);
      check({tag, "/busy4"}, bus4.busy,        (m_cnt[0] > 0 && !m_done[0]) ? 1 : 0);
      check({tag, "/op9"},   bus9.operand,     m_val[1]);
      check({tag, "/cnt9"},  bus9.digit_count, m_cnt[1]);
      check({tag, "/err9"},  bus9.err,         m_err[1]);
      check({tag, "/busy9"}, bus9.busy,        (m_cnt[1] > 0 && !m_done[1]) ? 1 : 0);
   endtask

   task automatic press(input bit clr, input bit cmt, input bit ent,
                        input logic [3:0] d, input int hold);
      longint pre4, pre9;
      pre4 = m_val[0];
      pre9 = m_val[1];
      @(negedge clk);
      digit = d; k_clr = clr; k_cmt = cmt; k_ent = ent;
      repeat (SS) @(posedge clk);
      #1;
      check("early_op4", bus4.operand, pre4);
      check("early_op9", bus9.operand, pre9);
      model_event(clr, cmt, ent, d);
      @(posedge clk);
      #1;
      check_outputs("press");
      check("valid4", bus4.valid, (q4.size() > 0) ? 1 : 0);
      check("valid9", bus9.valid, (q9.size() > 0) ? 1 : 0);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check_outputs("hold");
      end
      @(negedge clk);
      k_clr = 1'b0; k_cmt = 1'b0; k_ent = 1'b0;
      repeat (SS + 2) @(negedge clk);
   endtask

   task automatic enter_digit(input logic [3:0] d);
      press(1'b0, 1'b0, 1'b1, d, 0);
   endtask

   // Scoreboard monitors: every valid pulse must match a queued finalisation.
   always @(negedge clk) begin
      if (!rst && bus4.valid === 1'b1) begin
         if (q4.size() == 0) check("unexpected_valid4", bus4.valid, 0);
         else begin
            exp_t e;
            e = q4.pop_front();
            check("sb_op4", bus4.operand, e.op);
            check("sb_cnt4", bus4.digit_count, e.cnt);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus9.valid === 1'b1) begin
         if (q9.size() == 0) check("unexpected_valid9", bus9.valid, 0);
         else begin
            exp_t e;
            e = q9.pop_front();
            check("sb_op9", bus9.operand, e.op);
            check("sb_cnt9", bus9.digit_count, e.cnt);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      check("reset_valid4", bus4.valid, 0);
      check("reset_valid9", bus9.valid, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);

      press(1'b1, 1'b0, 1'b0, 4'd0, 0);
      enter_digit(4'd7); enter_digit(4'd5);
      press(1'b0, 1'b1, 1'b0, 4'd0, 0);
      enter_digit(4'd9);

      press(1'b1, 1'b0, 1'b0, 4'd0, 0);
      enter_digit(4'd3); enter_digit(4'd12); enter_digit(4'd8);
      press(1'b1, 1'b0, 1'b0, 4'd0, 0);

      press(1'b0, 1'b0, 1'b1, 4'd6, 50);

      press(1'b1, 1'b0, 1'b0, 4'd0, 0);
      enter_digit(4'd9); enter_digit(4'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      check("async_rst_valid4", bus4.valid, 0);
      check("async_rst_valid9", bus9.valid, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      enter_digit(4'd5);

      press(1'b1, 1'b0, 1'b0, 4'd0, 0);
      enter_digit(4'd4); enter_digit(4'd2);
      press(1'b1, 1'b1, 1'b1, 4'd5, 0);
      enter_digit(4'd4); enter_digit(4'd2);
      press(1'b0, 1'b1, 1'b1, 4'd5, 0);

      press(1'b1, 1'b0, 1'b0, 4'd0, 0);
      for (int i = 0; i < 9; i++) enter_digit(4'd9);

      for (int n = 0; n < 200; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 8)       press(1'b1, 1'b0, 1'b0, 4'd0, 0);
         else if (r < 18) press(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 9)), 0);
         else if (r < 24) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
         else if (r < 30) enter_digit(4'($urandom_range(10, 15)));
         else             enter_digit(4'($urandom_range(0, 9)));
      end

      repeat (4) @(negedge clk);
      check("sb_drained4", 64'(q4.size()), 0);
      check("sb_drained9", 64'(q9.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/calc_operand_entry.md
Name: calc_operand_entry

Overview:
- Parametrised multi-digit decimal operand builder for the stopwatch-calculator keypad path.
- Accepts one BCD digit per key press and accumulates operand = operand*10 + digit.
- Publishes the finished operand with a one-cycle valid pulse after DIGITS entries or an early commit.
- Sits between the keypad/switch front end and the calculator ALU. Replaces the fixed two-press entry scheme with a synchronised, edge-detected, clocked design.

Parameters:
- DIGITS, 4, maximum decimal digits per operand (1..9).
- DATA_W, 32, operand width. Must satisfy 10^DIGITS - 1 < 2^DATA_W; elaboration fails otherwise.
- SYNC_STAGES, 2, synchroniser flops on each key input (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- digit  in  4  BCD digit presented with key_enter; sampled on the accepted edge
- key_enter  in  1  raw asynchronous enter button, level
- key_commit  in  1  raw asynchronous commit button, level; finishes entry early
- key_clear  in  1  raw asynchronous clear button, level
- operand  out  DATA_W  accumulated value
- digit_count  out  4  digits accepted so far
- busy  out  1  high while in state ENTRY
- valid  out  1  one-cycle pulse when the operand is finalised
- err  out  1  sticky flag for a rejected digit (>9); cleared by clear or rst

Behaviour:
- Reset (async assert, released synchronously to clk):
  - operand=0, digit_count=0, busy=0, valid=0, err=0.
  - State=IDLE; all synchroniser and edge-detect flops are 0.
- Input conditioning:
  - Each key passes through SYNC_STAGES flops, then a rising-edge detector (current & ~previous).
  - A key held high gives exactly one event. No event on release.
  - Latency: the event is seen SYNC_STAGES+1 clk edges after the raw input rises. The operand update lands on that same edge.
  - digit is sampled unsynchronised on the event edge. The digit source must hold digit stable for SYNC_STAGES+2 cycles around the press.
- State machine: IDLE, ENTRY, DONE.
  - IDLE, enter event with digit<=9: operand<=digit, digit_count<=1, go to ENTRY. If DIGITS==1, go to DONE instead and pulse valid.
  - IDLE, commit event: ignored (no digits entered).
  - ENTRY, enter event with digit<=9: operand<=operand*10+digit, digit_count<=digit_count+1. If the new count equals DIGITS, go to DONE and pulse valid on the same edge as the final update.
  - ENTRY, commit event: go to DONE and pulse valid; operand is unchanged.
  - DONE: enter and commit events are ignored. operand and digit_count hold until clear.
  - Any state, clear event: operand<=0, digit_count<=0, err<=0, go to IDLE, no valid.
- Digit rejection:
  - An enter event with digit>9 sets err. operand, digit_count and state are unchanged.
- Simultaneous events in the same cycle:
  - Priority is clear > commit > enter.
  - In ENTRY, commit plus enter finalises without appending the digit.
- Arithmetic:
  - operand*10 is computed as (operand<<3)+(operand<<1) at DATA_W bits.
  - No overflow is possible under the parameter constraint, so there is no saturation logic.
- busy equals (state==ENTRY).
- valid is never high for two consecutive cycles.
- Reset mid-entry discards the partial operand immediately; no valid is produced.

Test Plan:
- Reset, then press enter with digits 1,2,3,4 (DIGITS=4):
  - operand steps 1, 12, 123, 1234.
  - valid pulses once, on the 4th update edge; state=DONE; digit_count=4.
- Press digits 7,5, then commit:
  - operand=75, valid pulse, digit_count=2.
  - A further enter with digit 9 leaves operand=75.
- Press digit 3, then digit 12 (invalid), then digit 8:
  - err=1 after the second press; final operand=38 with digit_count=2.
  - Clear then returns operand=0, err=0, state=IDLE.
- Hold key_enter high for 50 cycles with digit=6:
  - exactly one accept; operand=6, digit_count=1.
  - The first update occurs exactly SYNC_STAGES+1 cycles after the raw rise.
- In ENTRY with operand=42, raise clear, commit and enter in the same cycle:
  - result is IDLE, operand=0, no valid.
  - Repeat with only commit and enter together: operand=42, valid pulses, no append.
- Assert rst asynchronously mid-entry (operand=91):
  - all outputs go to 0 without waiting for a clock edge.
  - Next entry of 5 gives operand=5.
  - Also run DIGITS=9 with DATA_W=30 and digits 999999999: operand=999999999, valid pulses.
